// File: rtl/sr_pulse_ctrl_if.sv
// Button inputs and latch-drive outputs of sr_pulse_ctrl, grouped for port connection.
// Latency and backpressure are properties of the attached controller; this is wiring only.
// master: button source / latch side; slave: the pulse controller.
interface sr_pulse_ctrl_if;
    logic btn_set;
    logic btn_reset;
    logic s;
    logic r;
    logic busy;

    modport master (
        output btn_set,
        output btn_reset,
        input  s,
        input  r,
        input  busy
    );

    modport slave (
        input  btn_set,
        input  btn_reset,
        output s,
        output r,
        output busy
    );
endinterface

// File: rtl/sr_pulse_ctrl.sv
// Debounces two push-buttons into exclusive fixed-length set/reset pulses for an SR latch.
// Latency: press held from before edge 1 drives s/r high after edge DEBOUNCE+4, for PULSE_LEN cycles.
// No backpressure: requests that arrive while busy stay pending (reset first) and collapse per kind.
module sr_pulse_ctrl #(
    parameter int DEBOUNCE  = 4,
    parameter int PULSE_LEN = 2
) (
    input  logic         clock,
    input  logic         reset_n,
    sr_pulse_ctrl_if.slave bus
);
    localparam int CW      = $clog2(DEBOUNCE + 1);
    localparam int PW      = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam int SET_IDX = 0;
    localparam int RST_IDX = 1;

    typedef enum logic [1:0] {IDLE, SET_P, RST_P, GUARD} state_t;

    logic [1:0]         raw;
    logic [1:0]         sync1;
    logic [1:0]         sync2;
    logic [1:0]         stable;
    logic [1:0]         stable_q;
    logic [1:0][CW-1:0] db_cnt;
    logic [1:0]         pend;
    logic [1:0]         rise;
    logic [1:0]         acc;
    logic [PW-1:0]      pcnt;
    state_t             state;

    assign raw  = {bus.btn_reset, bus.btn_set};
    assign rise = stable & ~stable_q;

    // Synchroniser plus per-button debounce: stable only flips after DEBOUNCE differing cycles.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_q <= '0;
            db_cnt   <= '0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            stable_q <= stable;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CW'(DEBOUNCE - 1)) begin
                    stable[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        acc = 2'b00;
        if (state == IDLE) begin
            if (pend[RST_IDX])      acc[RST_IDX] = 1'b1;
            else if (pend[SET_IDX]) acc[SET_IDX] = 1'b1;
        end
    end

    // s/r/busy are registered alongside the state so only one of s/r can ever be high.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= IDLE;
            pcnt     <= '0;
            pend     <= '0;
            bus.s    <= 1'b0;
            bus.r    <= 1'b0;
            bus.busy <= 1'b0;
        end else begin
            pend <= (pend & ~acc) | rise;
            case (state)
                IDLE: begin
                    pcnt <= PW'(PULSE_LEN - 1);
                    if (pend[RST_IDX]) begin
                        state    <= RST_P;
                        bus.r    <= 1'b1;
                        bus.busy <= 1'b1;
                    end else if (pend[SET_IDX]) begin
                        state    <= SET_P;
                        bus.s    <= 1'b1;
                        bus.busy <= 1'b1;
                    end
                end
                SET_P, RST_P: begin
                    if (pcnt == '0) begin
                        state <= GUARD;
                        bus.s <= 1'b0;
                        bus.r <= 1'b0;
                    end else begin
                        pcnt <= pcnt - 1'b1;
                    end
                end
                GUARD: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    bus.s    <= 1'b0;
                    bus.r    <= 1'b0;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule
